// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one 32-bit ALU between two requesters, with
// multi-cycle multiply sequencing and a single tagged, backpressured response.
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o
);

  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_MUL = 3'b111;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [2:0]  op_ctrl_q, op_ctrl_d;
  logic        op_id_q, op_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_zero_q, rsp_zero_d;

  logic        grant0, grant1, accept;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_ctrl;

  // Ties go to the requester that did not win last time.
  always_comb begin
    grant0 = (state_q == IDLE) && !rst_i && req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1 = (state_q == IDLE) && !rst_i && req1_valid_i && (!req0_valid_i || !last_grant_q);
    accept = grant0 || grant1;
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // In IDLE the ALU sees the granted request; otherwise the captured operands.
  always_comb begin
    if (state_q == IDLE) begin
      alu_a    = grant1 ? req1_data1_i : req0_data1_i;
      alu_b    = grant1 ? req1_data2_i : req0_data2_i;
      alu_ctrl = grant1 ? req1_ctrl_i  : req0_ctrl_i;
    end else begin
      alu_a    = op_a_q;
      alu_b    = op_b_q;
      alu_ctrl = op_ctrl_q;
    end
  end

  always_comb begin
    case (alu_ctrl)
      CTRL_ADD: alu_res = alu_a + alu_b;
      CTRL_SUB: alu_res = alu_a - alu_b;
      CTRL_AND: alu_res = alu_a & alu_b;
      CTRL_OR:  alu_res = alu_a | alu_b;
      CTRL_MUL: alu_res = alu_a * alu_b;
      default:  alu_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_ctrl_d    = op_ctrl_q;
    op_id_d      = op_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d       = alu_a;
          op_b_d       = alu_b;
          op_ctrl_d    = alu_ctrl;
          op_id_d      = grant1;
          last_grant_d = grant1;
          if ((alu_ctrl == CTRL_MUL) && (MUL_LAT > 1)) begin
            state_d = EXEC;
            cnt_d   = MUL_CNT;
          end else begin
            state_d    = DONE;
            rsp_data_d = alu_res;
            rsp_id_d   = grant1;
            rsp_zero_d = (alu_res == 32'd0);
          end
        end
      end
      EXEC: begin
        if (cnt_q <= 4'd1) begin
          state_d    = DONE;
          cnt_d      = 4'd0;
          rsp_data_d = alu_res;
          rsp_id_d   = op_id_q;
          rsp_zero_d = (alu_res == 32'd0);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      op_ctrl_q    <= 3'd0;
      op_id_q      <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_id_q     <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_ctrl_q    <= op_ctrl_d;
      op_id_q      <= op_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid_o = (state_q == DONE);
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_zero_o  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (MUL_LAT = 3): arbitration order, latencies,
// backpressure, illegal code and reset during a multiply.
module tb_alu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req0_ready_o;
  logic [31:0] req0_data1_i, req0_data2_i;
  logic [2:0]  req0_ctrl_i;
  logic        req1_valid_i, req1_ready_o;
  logic [31:0] req1_data1_i, req1_data2_i;
  logic [2:0]  req1_ctrl_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o;
  logic [31:0] rsp_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.MUL_LAT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_readies(input string tag, input logic r0, input logic r1);
    check({tag, " ready0"}, {31'd0, req0_ready_o}, {31'd0, r0});
    check({tag, " ready1"}, {31'd0, req1_ready_o}, {31'd0, r1});
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] data, input logic zero);
    check({tag, " valid"}, {31'd0, rsp_valid_o}, {31'd0, v});
    check({tag, " id"},    {31'd0, rsp_id_o},    {31'd0, id});
    check({tag, " data"},  rsp_data_o,           data);
    check({tag, " zero"},  {31'd0, rsp_zero_o},  {31'd0, zero});
    $display("rsp %s: valid=%0b id=%0d data=0x%08h zero=%0b", tag, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; rsp_ready_i = 1'b0;
    req0_valid_i = 1'b0; req0_data1_i = '0; req0_data2_i = '0; req0_ctrl_i = '0;
    req1_valid_i = 1'b0; req1_data1_i = '0; req1_data2_i = '0; req1_ctrl_i = '0;
    cyc(); cyc();
    chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
    chk_readies("reset", 1'b0, 1'b0);
    rst_i = 1'b0;

    // req0 add 5 + 7
    cyc();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_data1_i = 32'd5; req0_data2_i = 32'd7; req0_ctrl_i = 3'b010;
    #1 chk_readies("add accept", 1'b1, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    #1 chk_rsp("add", 1'b1, 1'b0, 32'd12, 1'b0);
    chk_readies("add done", 1'b0, 1'b0);
    cyc();
    #1 check("add handshake valid", {31'd0, rsp_valid_o}, 32'd0);

    // Tie after req0 won: req1 multiply wins, req0 AND waits through it
    req1_valid_i = 1'b1; req1_data1_i = 32'h0001_0000; req1_data2_i = 32'h0001_0000; req1_ctrl_i = 3'b111;
    req0_valid_i = 1'b1; req0_data1_i = 32'hFFFF_0000; req0_data2_i = 32'h0F0F_0F0F; req0_ctrl_i = 3'b000;
    #1 chk_readies("mul accept", 1'b0, 1'b1);
    cyc();
    req1_valid_i = 1'b0; req1_data1_i = 32'd5; req1_data2_i = 32'd6; req1_ctrl_i = 3'b010;
    for (int k = 1; k <= 2; k++) begin
      #1 check($sformatf("mul busy%0d valid", k), {31'd0, rsp_valid_o}, 32'd0);
      chk_readies($sformatf("mul busy%0d", k), 1'b0, 1'b0);
      cyc();
    end
    #1 chk_rsp("mul", 1'b1, 1'b1, 32'd0, 1'b1);
    chk_readies("mul done", 1'b0, 1'b0);
    cyc();

    // AND under backpressure, req1 illegal op waiting
    #1 chk_readies("and accept", 1'b1, 1'b0);
    rsp_ready_i = 1'b0;
    cyc();
    req0_valid_i = 1'b0; req0_data1_i = 32'hDEAD_BEEF; req0_data2_i = 32'hFFFF_FFFF;
    req1_valid_i = 1'b1; req1_data1_i = 32'd9; req1_data2_i = 32'd9; req1_ctrl_i = 3'b100;
    for (int k = 1; k <= 5; k++) begin
      #1 chk_rsp($sformatf("and hold%0d", k), 1'b1, 1'b0, 32'h0F0F_0000, 1'b0);
      chk_readies($sformatf("and hold%0d", k), 1'b0, 1'b0);
      cyc();
    end
    rsp_ready_i = 1'b1;
    #1 chk_rsp("and release", 1'b1, 1'b0, 32'h0F0F_0000, 1'b0);
    cyc();
    #1 chk_readies("illegal accept", 1'b0, 1'b1);
    cyc();
    req1_valid_i = 1'b0;
    #1 chk_rsp("illegal", 1'b1, 1'b1, 32'd0, 1'b1);
    cyc();
    #1 check("illegal handshake valid", {31'd0, rsp_valid_o}, 32'd0);

    // Both valid continuously: grants 0,1,0,1
    req0_valid_i = 1'b1; req0_data1_i = 32'd3; req0_data2_i = 32'd3; req0_ctrl_i = 3'b110;
    req1_valid_i = 1'b1; req1_data1_i = 32'hF0; req1_data2_i = 32'h0F; req1_ctrl_i = 3'b001;
    for (int i = 0; i < 2; i++) begin
      #1 chk_readies($sformatf("tie%0d g0", i), 1'b1, 1'b0);
      cyc();
      #1 chk_rsp($sformatf("tie%0d sub", i), 1'b1, 1'b0, 32'd0, 1'b1);
      cyc();
      #1 chk_readies($sformatf("tie%0d g1", i), 1'b0, 1'b1);
      cyc();
      #1 chk_rsp($sformatf("tie%0d or", i), 1'b1, 1'b1, 32'hFF, 1'b0);
      if (i == 1) begin
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      end
      cyc();
    end

    // Reset during a req0 multiply
    req0_valid_i = 1'b1; req0_data1_i = 32'd3; req0_data2_i = 32'd4; req0_ctrl_i = 3'b111;
    #1 chk_readies("rstmul accept", 1'b1, 1'b0);
    cyc();
    req0_valid_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    #1 chk_rsp("after reset", 1'b0, 1'b0, 32'd0, 1'b0);
    cyc();
    #1 check("no late rsp valid", {31'd0, rsp_valid_o}, 32'd0);
    req0_valid_i = 1'b1; req0_data1_i = 32'd1; req0_data2_i = 32'd2; req0_ctrl_i = 3'b010;
    req1_valid_i = 1'b1; req1_data1_i = 32'd1; req1_data2_i = 32'd6; req1_ctrl_i = 3'b001;
    #1 chk_readies("post-reset tie", 1'b1, 1'b0);
    cyc();
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    #1 chk_rsp("post-reset add", 1'b1, 1'b0, 32'd3, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
